// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: pin conditioning, 11-bit frame deserialiser and show-ahead FIFO.
// Define PS2_TIMEOUT_EN to abort stalled frames after TIMEOUT_CYCLES idle clocks.
module ps2_rx #(
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned FILTER_LEN     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 2500
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_ps2_clk,
    input  logic                        i_ps2_data,
    output logic [7:0]                  o_data_out,
    output logic                        o_valid,
    input  logic                        i_ready,
    output logic                        o_parity_err,
    output logic                        o_frame_err,
    output logic                        o_overflow,
    output logic [$clog2(FIFO_DEPTH):0] o_fifo_count
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned FLT_W = $clog2(FILTER_LEN + 1);
    localparam logic [FLT_W-1:0] FLT_LAST = FLT_W'(FILTER_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

    logic [1:0]       r_clk_sync, r_data_sync;
    logic             r_clk_filt, r_clk_filt_q;
    logic [FLT_W-1:0] r_flt_cnt;
    logic             w_fall, w_data;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_clk_sync   <= 2'b11;
            r_data_sync  <= 2'b11;
            r_clk_filt   <= 1'b1;
            r_clk_filt_q <= 1'b1;
            r_flt_cnt    <= '0;
        end else begin
            r_clk_sync   <= {r_clk_sync[0], i_ps2_clk};
            r_data_sync  <= {r_data_sync[0], i_ps2_data};
            r_clk_filt_q <= r_clk_filt;
            if (r_clk_sync[1] != r_clk_filt) begin
                if (r_flt_cnt == FLT_LAST) begin
                    r_clk_filt <= r_clk_sync[1];
                    r_flt_cnt  <= '0;
                end else begin
                    r_flt_cnt <= r_flt_cnt + 1'b1;
                end
            end else begin
                r_flt_cnt <= '0;
            end
        end
    end

    assign w_fall = r_clk_filt_q & ~r_clk_filt;
    assign w_data = r_data_sync[1];

    state_e     r_state;
    logic [2:0] r_bit_cnt;
    logic [7:0] r_shift, r_push_byte;
    logic       r_par, r_push, r_parity_err, r_frame_err;

`ifdef PS2_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    logic [TO_W-1:0] r_to_cnt;
`else
    logic w_unused_timeout;
    assign w_unused_timeout = ^TIMEOUT_CYCLES;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= StIdle;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_par        <= 1'b0;
            r_push       <= 1'b0;
            r_push_byte  <= '0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
`ifdef PS2_TIMEOUT_EN
            r_to_cnt     <= '0;
`endif
        end else begin
            r_push       <= 1'b0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
            if (w_fall) begin
`ifdef PS2_TIMEOUT_EN
                r_to_cnt <= '0;
`endif
                unique case (r_state)
                    StIdle: begin
                        // A high "start" bit is a stray edge, not a frame.
                        if (!w_data) begin
                            r_state   <= StData;
                            r_bit_cnt <= '0;
                        end
                    end
                    StData: begin
                        r_shift   <= {w_data, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                        if (r_bit_cnt == 3'd7) r_state <= StParity;
                    end
                    StParity: begin
                        r_par   <= w_data;
                        r_state <= StStop;
                    end
                    StStop: begin
                        r_state <= StIdle;
                        if (!w_data) begin
                            r_frame_err <= 1'b1;
                        end else if (!(^{r_shift, r_par})) begin
                            r_parity_err <= 1'b1;
                        end else begin
                            r_push      <= 1'b1;
                            r_push_byte <= r_shift;
                        end
                    end
                    default: r_state <= StIdle;
                endcase
            end
`ifdef PS2_TIMEOUT_EN
            else if (r_state == StIdle) begin
                r_to_cnt <= '0;
            end else if (r_to_cnt == TO_LAST) begin
                r_state     <= StIdle;
                r_frame_err <= 1'b1;
                r_to_cnt    <= '0;
            end else begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end
`endif
        end
    end

    logic [7:0]       r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr, w_rd_next;
    logic [CNT_W-1:0] r_count, w_count_d;
    logic [7:0]       r_data_out, w_head_d;
    logic             r_valid, r_overflow;
    logic             w_pop, w_full, w_wr, w_ovf;

    always_comb begin
        w_pop     = r_valid & i_ready;
        w_full    = (r_count == CNT_FULL);
        w_wr      = r_push & (~w_full | w_pop);
        w_ovf     = r_push & w_full & ~w_pop;
        w_rd_next = w_pop ? r_rd_ptr + 1'b1 : r_rd_ptr;
        w_count_d = r_count;
        if (w_wr && !w_pop) w_count_d = r_count + 1'b1;
        else if (!w_wr && w_pop) w_count_d = r_count - 1'b1;
        // The new head bypasses storage when the FIFO is (or is about to be) empty.
        w_head_d = r_data_out;
        if (w_wr && (r_count == '0 || (w_pop && r_count == CNT_W'(1)))) w_head_d = r_push_byte;
        else if (w_count_d != '0) w_head_d = r_mem[w_rd_next];
    end

    always_ff @(posedge i_clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= r_push_byte;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_valid    <= 1'b0;
            r_data_out <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            r_rd_ptr   <= w_rd_next;
            r_count    <= w_count_d;
            r_valid    <= (w_count_d != '0);
            r_data_out <= w_head_d;
            r_overflow <= w_ovf;
        end
    end

    assign o_data_out   = r_data_out;
    assign o_valid      = r_valid;
    assign o_fifo_count = r_count;
    assign o_parity_err = r_parity_err;
    assign o_frame_err  = r_frame_err;
    assign o_overflow   = r_overflow;
endmodule
